ks_nibble_seq_adder: RTL

Multi-cycle WIDTH-bit adder/subtractor that time-multiplexes one instance of the team's 4-bit KoggeStone adder, one nibble per clock, LSB first. It registers the inter-slice carry and the partial sum between cycles. It sits directly upstream and downstream of that slice: it supplies each nibble and carry to the slice and captures the slice's Sum and Cout. Operands arrive and results leave over valid/ready handshakes.

---
 rtl/ks_nibble_seq_adder_if.sv | 26 ++
 rtl/ks_nibble_seq_adder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ks_nibble_seq_adder_if.sv
// rtl/ks_nibble_seq_adder_if.sv - operand/result handshake bundle for the nibble-serial adder
interface ks_nibble_seq_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/ks_nibble_seq_adder.sv
// rtl/ks_nibble_seq_adder.sv - WIDTH-bit add/sub, one 4-bit Kogge-Stone slice reused per nibble
// The slice sees A, Beff and the carry register; results accumulate in sum_q LSB nibble first.

module ks_adder4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  logic [3:0] g0, p0, g1, p1, g2, p2;
  logic [4:0] c;

  assign g0 = a_i & b_i;
  assign p0 = a_i ^ b_i;

  // prefix level 1: span 2
  assign g1[0] = g0[0];
  assign p1[0] = p0[0];
  assign g1[1] = g0[1] | (p0[1] & g0[0]);
  assign p1[1] = p0[1] & p0[0];
  assign g1[2] = g0[2] | (p0[2] & g0[1]);
  assign p1[2] = p0[2] & p0[1];
  assign g1[3] = g0[3] | (p0[3] & g0[2]);
  assign p1[3] = p0[3] & p0[2];

  // prefix level 2: span 4
  assign g2[0] = g1[0];
  assign p2[0] = p1[0];
  assign g2[1] = g1[1];
  assign p2[1] = p1[1];
  assign g2[2] = g1[2] | (p1[2] & g1[0]);
  assign p2[2] = p1[2] & p1[0];
  assign g2[3] = g1[3] | (p1[3] & g1[1]);
  assign p2[3] = p1[3] & p1[1];

  assign c[0] = cin_i;
  assign c[1] = g2[0] | (p2[0] & cin_i);
  assign c[2] = g2[1] | (p2[1] & cin_i);
  assign c[3] = g2[2] | (p2[2] & cin_i);
  assign c[4] = g2[3] | (p2[3] & cin_i);

  assign sum_o  = p0 ^ c[3:0];
  assign cout_o = c[4];
endmodule

module ks_nibble_seq_adder #(
  parameter int WIDTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  ks_nibble_seq_adder_if.slave bus
);
  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("ks_nibble_seq_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       slice_a, slice_b, slice_sum;
  logic             slice_cout;
  logic             last_slice;

  assign slice_a    = a_q[4*k_q +: 4];
  assign slice_b    = b_q[4*k_q +: 4];
  assign last_slice = (k_q == KW'(N - 1));

  ks_adder4 u_slice (
    .a_i   (slice_a),
    .b_i   (slice_b),
    .cin_i (carry_q),
    .sum_o (slice_sum),
    .cout_o(slice_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    k_d     = k_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // subtraction folds into the add: invert B and force the carry-in
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub | bus.cin;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[4*k_q +: 4] = slice_sum;
        carry_d           = slice_cout;
        k_d               = k_q + KW'(1);
        if (last_slice) begin
          cout_d  = slice_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (slice_sum[3] != a_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule
